// File: rtl/serial_key_sequencer.sv
// Serial key-device access sequencer: per command, a setup/strobe/sample bus cycle on the key
// interface, shifting sdrd into a response that is offered to the host after the last access.
module serial_key_sequencer #(
  parameter int unsigned SETUP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_nib,
  input  logic       cmd_last,
  input  logic       abort,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_count,
  output logic       key_sser_n,
  output logic       key_ba13,
  output logic       key_ba12,
  output logic [3:0] key_ba,
  output logic       key_br_w,
  output logic       key_clk,
  input  logic       sdrd
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StSample, StResp} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] nib_q, nib_d;
  logic       last_q, last_d;
  logic [7:0] data_q, data_d;
  logic [3:0] count_q, count_d;
  logic       sel_d;

  logic       cmd_ready_q, rsp_valid_q;
  logic       key_sser_n_q, key_ba12_q, key_br_w_q, key_clk_q;
  logic [3:0] key_ba_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    last_d  = last_q;
    data_d  = data_q;
    count_d = count_q;
    if (abort) begin
      // Abort wins over any handshake and discards a pending response.
      state_d = StIdle;
      data_d  = 8'h00;
      count_d = 4'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            state_d = StSetup;
            cnt_d   = 4'(SETUP_CYC - 1);
            nib_d   = cmd_nib;
            last_d  = cmd_last;
          end
        end
        StSetup: begin
          if (cnt_q == 4'h0) state_d = StStrobe;
          else cnt_d = cnt_q - 4'h1;
        end
        StStrobe: state_d = StSample;
        StSample: begin
          data_d  = {data_q[6:0], sdrd};
          count_d = (count_q == 4'hf) ? 4'hf : count_q + 4'h1;
          state_d = last_q ? StResp : StIdle;
        end
        StResp: begin
          if (rsp_ready) begin
            state_d = StIdle;
            data_d  = 8'h00;
            count_d = 4'h0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign sel_d = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StSample);

  // Bus outputs are registered from the next state so they change cleanly on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'h0;
      nib_q        <= 4'h0;
      last_q       <= 1'b0;
      data_q       <= 8'h00;
      count_q      <= 4'h0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      key_sser_n_q <= 1'b1;
      key_ba12_q   <= 1'b0;
      key_br_w_q   <= 1'b0;
      key_clk_q    <= 1'b0;
      key_ba_q     <= 4'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nib_q        <= nib_d;
      last_q       <= last_d;
      data_q       <= data_d;
      count_q      <= count_d;
      cmd_ready_q  <= (state_d == StIdle);
      rsp_valid_q  <= (state_d == StResp);
      key_sser_n_q <= ~sel_d;
      key_ba12_q   <= sel_d;
      key_br_w_q   <= sel_d;
      key_clk_q    <= (state_d == StStrobe);
      key_ba_q     <= sel_d ? nib_d : 4'h0;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = data_q;
  assign rsp_count  = count_q;
  assign key_sser_n = key_sser_n_q;
  assign key_ba13   = 1'b0;
  assign key_ba12   = key_ba12_q;
  assign key_ba     = key_ba_q;
  assign key_br_w   = key_br_w_q;
  assign key_clk    = key_clk_q;

endmodule

// File: tb/tb_serial_key_sequencer.sv
// Directed bench for serial_key_sequencer with a response scoreboard and a bit-level model.
module tb_serial_key_sequencer;

  localparam int unsigned SetupCyc = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_nib = 4'h0;
  logic       cmd_last = 1'b0;
  logic       abort = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [3:0] rsp_count;
  logic       key_sser_n, key_ba13, key_ba12, key_br_w, key_clk;
  logic [3:0] key_ba;
  logic       sdrd = 1'b0;

  int checks = 0;
  int failures = 0;
  int clk_pulses = 0;
  logic [7:0]  exp_data = 8'h00;
  logic [3:0]  exp_count = 4'h0;
  logic [11:0] exp_q[$];

  serial_key_sequencer #(.SETUP_CYC(SetupCyc)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_nib(cmd_nib), .cmd_last(cmd_last), .abort(abort), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_count(rsp_count),
    .key_sser_n(key_sser_n), .key_ba13(key_ba13), .key_ba12(key_ba12), .key_ba(key_ba),
    .key_br_w(key_br_w), .key_clk(key_clk), .sdrd(sdrd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (key_clk) clk_pulses <= clk_pulses + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_sser_n"}, 32'(key_sser_n), 32'd1);
    chk({tag, "_key_clk"}, 32'(key_clk), 32'd0);
    chk({tag, "_key_ba"}, 32'(key_ba), 32'd0);
    chk({tag, "_ba13"}, 32'(key_ba13), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_idle_bus(tag);
    chk({tag, "_ba12"}, 32'(key_ba12), 32'd0);
    chk({tag, "_br_w"}, 32'(key_br_w), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_count"}, 32'(rsp_count), 32'd0);
  endtask

  // One access; abort_at (1-based cycle after accept) cancels it, 0 means run to completion.
  task automatic do_access(input logic [3:0] nib, input logic last, input logic bit_in,
                           input int abort_at);
    int guard = 0;
    while (!cmd_ready && guard < 20) begin
      step();
      guard++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_nib   = nib;
    cmd_last  = last;
    sdrd      = bit_in;
    step();
    cmd_valid = 1'b0;
    cmd_nib   = 4'h0;
    cmd_last  = 1'b0;
    for (int c = 1; c <= int'(SetupCyc) + 2; c++) begin
      chk("acc_sser_n", 32'(key_sser_n), 32'd0);
      chk("acc_ba", 32'(key_ba), 32'(nib));
      chk("acc_ba12_brw", {30'd0, key_ba12, key_br_w}, 32'd3);
      chk("acc_key_clk", 32'(key_clk), (c == int'(SetupCyc) + 1) ? 32'd1 : 32'd0);
      chk("acc_cmd_ready", 32'(cmd_ready), 32'd0);
      if (c == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle_bus("abort");
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_count", 32'(rsp_count), 32'd0);
        chk("abort_rsp_data", 32'(rsp_data), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_data  = 8'h00;
        exp_count = 4'h0;
        return;
      end
      step();
    end
    exp_data  = {exp_data[6:0], bit_in};
    exp_count = (exp_count == 4'hf) ? 4'hf : exp_count + 4'h1;
    chk_idle_bus("post_acc");
    chk("post_acc_rsp_valid", 32'(rsp_valid), 32'(last));
    if (last) begin
      exp_q.push_back({exp_data, exp_count});
      exp_data  = 8'h00;
      exp_count = 4'h0;
    end
  endtask

  task automatic get_rsp(input int hold);
    logic [11:0] e;
    int guard = 0;
    while (!rsp_valid && guard < 50) begin
      step();
      guard++;
    end
    chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("rsp_data", 32'(rsp_data), 32'(e[11:4]));
    chk("rsp_count", 32'(rsp_count), 32'(e[3:0]));
    for (int i = 0; i < hold; i++) begin
      step();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data), 32'(e[11:4]));
      chk("bp_rsp_count", 32'(rsp_count), 32'(e[3:0]));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hs_rsp_data", 32'(rsp_data), 32'd0);
    chk("hs_rsp_count", 32'(rsp_count), 32'd0);
    chk("hs_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int p0;
    logic [8:0] pat;
    logic b;

    // Reset state
    step();
    step();
    chk_reset_vals("reset");
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    rsp_ready = 1'b1;  // must be ignored outside RESP
    rst_n = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("after_reset_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single access
    p0 = clk_pulses;
    do_access(4'hA, 1'b1, 1'b1, 0);
    chk("single_pulses", 32'(clk_pulses - p0), 32'd1);
    get_rsp(0);

    // Nine-access sequence with backpressure
    pat = 9'b101100101;
    p0 = clk_pulses;
    for (int i = 0; i < 9; i++) do_access(4'(i), (i == 8), pat[8 - i], 0);
    chk("seq9_pulses", 32'(clk_pulses - p0), 32'd9);
    chk("seq9_q_head", 32'(exp_q[0]), 32'h659);
    get_rsp(10);

    // Abort in STROBE of the third access
    do_access(4'h1, 1'b0, 1'b1, 0);
    do_access(4'h2, 1'b0, 1'b1, 0);
    do_access(4'h3, 1'b0, 1'b1, int'(SetupCyc) + 1);
    step();
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    do_access(4'h4, 1'b1, 1'b0, 0);
    get_rsp(0);

    // Reset during SETUP
    cmd_valid = 1'b1;
    cmd_nib   = 4'h7;
    cmd_last  = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("rst_mid_sser_n", 32'(key_sser_n), 32'd0);
    rst_n = 1'b0;
    step();
    chk_reset_vals("rst_mid");
    rst_n = 1'b1;
    step();
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);

    // Saturation over 17 accesses
    for (int i = 0; i < 17; i++) begin
      b = 1'($urandom_range(0, 1));
      do_access(4'(i), (i == 16), b, 0);
    end
    get_rsp(2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
